sseg_scan_driver: RTL and testbench
===================================

# sseg_scan_driver

Parametrised, time-multiplexed driver for common-anode seven-segment displays; the generalised successor to the fixed four-digit display block. Scans DIGITS digits, decodes 4-bit hex per digit, and adds per-digit decimal point and blanking, leading-zero suppression, and PWM brightness. Values are double-buffered and committed only at frame boundaries, so no frame is ever torn. Sits between the datapath and the board pins (AN*, CA..CG, DP).

## Interface
Parameters:
- DIGITS, 4: number of multiplexed digits (1..8).
- DIV_LOG2, 16: log2 of clock cycles per digit slot.
- BRIGHT_W, 3: brightness control width; DIV_LOG2 >= BRIGHT_W required.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- load  in  1  strobe: capture value, dp_in and blank_in into the shadow registers.
- value  in  4*DIGITS  hex nibbles; nibble i shows on digit i (digit 0 is rightmost).
- dp_in  in  DIGITS  per-digit decimal point enable.
- blank_in  in  DIGITS  per-digit blank: anode off.
- lz_suppress  in  1  leading-zero suppression enable (live, not buffered).
- brightness  in  BRIGHT_W  on-time level; all-ones gives full on.
- an  out  DIGITS  anodes, active-low.
- seg  out  7  {CG,CF,CE,CD,CC,CB,CA}, active-low.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse in the first output cycle of digit 0.
- pending  out  1  shadow holds data not yet committed.

## Operation
- Slot counter cnt (DIV_LOG2 bits) increments every cycle; on wrap, digit index idx advances 0 to DIGITS-1, then back to 0.
- Frame boundary: cycle with cnt all-ones and idx = DIGITS-1. At a boundary, active <= shadow and pending <= 0.
- load: shadow <= inputs and pending <= 1. With multiple loads in one frame, the last one wins. A load in a boundary cycle bypasses to active directly and leaves pending 0.
- Decode: hex 0..F to the standard segment pattern (0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 8=7'h00, A=7'h08, F=7'h0E).
- Leading-zero suppression: when lz_suppress=1, zero digits are suppressed from DIGITS-1 downward until the first nonzero digit. Digit 0 is never suppressed.
- Blanked or suppressed digit: an bit high, seg=7'h7F, dp=1.
- Brightness: the anode is driven low only while cnt[DIV_LOG2-1 -: BRIGHT_W] <= brightness. seg and dp are driven regardless.

## Timing
- Reset values: an all-ones, seg=7'h7F, dp=1, frame_start=0, pending=0. cnt, idx, shadow and active all clear to 0.
- All outputs are registered. Pins in cycle t+1 reflect cnt, idx and active in cycle t.
- Each digit occupies 2^DIV_LOG2 cycles; a frame is DIGITS*2^DIV_LOG2 cycles. frame_start fires every frame, starting with the first frame after reset.
- A committed value appears on the pins at the next frame_start. Worst-case latency from load to display is one frame plus 1 cycle.
- rst asserted mid-frame: outputs take reset values on the next edge, and the scan restarts at idx 0, cnt 0. Pending data is lost.
- lz_suppress, brightness, dp/blank application: sampled every cycle through the output register (1-cycle latency), not frame-buffered.

## Structure
- Package sseg_pkg: hex-to-segment constant table, SEG_BLANK=7'h7F, and the function returning the brightness on-time compare.
- Sub-module sseg_hex_decode: combinational, 4-bit in, 7-bit active-low out, built from the package table.
- Top level: counter/index, shadow/active registers with commit logic, suppression mask, output registers.

## Test plan
All scenarios use DIGITS=4, DIV_LOG2=2, BRIGHT_W=2; a frame is 16 cycles.
- rst held 3 cycles -> an=4'hF, seg=7'h7F, dp=1, pending=0, frame_start=0. The first frame_start occurs 1 cycle after the first 16-cycle frame completes.
- load value=16'h12A8, dp_in=4'b0100, brightness=3 -> pending=1 until the boundary.
  - Next frame: an=1110 for 4 cycles with seg=7'h00, then 1101 with seg=7'h08.
  - Then 1011 with seg=7'h24 and dp=0, then 0111 with seg=7'h79.
- lz_suppress=1, value=16'h0030 -> digits 3 and 2 show an bit high and seg=7'h7F; digit 1 shows seg=7'h30; digit 0 shows seg=7'h40.
- brightness=1 -> within each 4-cycle slot, the anode is low for 2 cycles and high for 2; seg stays constant across the slot.
- Load sequence 16'h0001, 16'h0002 mid-frame, then 16'hFFFF in the boundary cycle -> next frame shows FFFF (seg=7'h0E), pending=0. The mid-frame values are never displayed.
- rst pulsed mid-slot of digit 2 -> next cycle: reset outputs, active cleared. After release, the scan restarts at digit 0 and shows 0 on all digits.

Source files
------------

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants and helpers for the seven-segment scan driver.
//   HEX_SEG_TABLE : active-low {CG..CA} pattern for each hex nibble (index = nibble)
//   SEG_BLANK     : all segments off
//   bright_on()   : brightness on-time compare for the current slot phase
package sseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Element [15] is leftmost, so the table reads F..0 from left to right.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Anode may be on while the top bits of the slot counter do not exceed the
    // brightness level; both operands arrive zero-extended to 8 bits.
    function automatic logic bright_on(input logic [7:0] phase, input logic [7:0] level);
        return (phase <= level);
    endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// sseg_hex_decode: combinational hex nibble to active-low segment decoder.
//   hex_i [3:0] : nibble to display
//   seg_o [6:0] : {CG,CF,CE,CD,CC,CB,CA}, active-low
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG_TABLE[hex_i];

endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: time-multiplexed common-anode seven-segment driver.
//   clk, rst          : clock and synchronous active-high reset
//   load              : capture value/dp_in/blank_in into the shadow registers
//   value [4*DIGITS]  : hex nibbles, nibble i on digit i (digit 0 rightmost)
//   dp_in, blank_in   : per-digit decimal point enable and blanking
//   lz_suppress       : live leading-zero suppression enable
//   brightness        : PWM on-time level, all-ones is full on
//   an, seg, dp       : registered active-low pin drives
//   frame_start       : pulse in the first output cycle of digit 0
//   pending           : shadow holds data not yet committed to the display
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DIV_LOG2 = 16,
    parameter int BRIGHT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lz_suppress,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_start,
    output logic                  pending
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [DIV_LOG2-1:0] cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [4*DIGITS-1:0] sh_val_q, act_val_q;
    logic [DIGITS-1:0]   sh_dp_q, act_dp_q, sh_blank_q, act_blank_q;
    logic                pending_q, bnd_q, frame_start_q;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d, dec_seg_s;
    logic                dp_q, dp_d;
    logic                boundary_s, off_s, on_s, lead_s;
    logic [3:0]          cur_nib_s;
    logic [DIGITS-1:0]   sup_s;

    // Last cycle of the last digit slot: the only point where a commit happens.
    always_comb boundary_s = (&cnt_q) && (idx_q == LAST_IDX);

    // Nibble of the digit currently being scanned.
    always_comb cur_nib_s = act_val_q[4*idx_q +: 4];

    sseg_hex_decode u_dec (
        .hex_i (cur_nib_s),
        .seg_o (dec_seg_s)
    );

    // Leading-zero mask: walk down from the top digit while nibbles stay zero;
    // digit 0 is never part of the mask so a zero value still shows "0".
    always_comb begin
        lead_s = lz_suppress;
        sup_s  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead_s   = lead_s & (act_val_q[4*i +: 4] == 4'h0);
            sup_s[i] = lead_s;
        end
    end

    // Digit dark (blanked or suppressed) and PWM on-phase for this cycle.
    always_comb begin
        off_s = act_blank_q[idx_q] | sup_s[idx_q];
        on_s  = bright_on(8'(cnt_q[DIV_LOG2-1 -: BRIGHT_W]), 8'(brightness));
    end

    // Next pin values; seg/dp stay driven through the PWM off-phase.
    always_comb begin
        an_d = '1;
        if (!off_s && on_s) begin
            an_d[idx_q] = 1'b0;
        end else begin
            an_d = '1;
        end
        if (off_s) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end else begin
            seg_d = dec_seg_s;
            dp_d  = ~act_dp_q[idx_q];
        end
    end

    // Slot counter and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_LOG2'(1);
            if (&cnt_q) begin
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end else begin
                idx_q <= idx_q;
            end
        end
    end

    // Double buffer. A load on the boundary also refreshes the shadow, otherwise
    // the next boundary would copy a stale shadow back over the bypassed value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_val_q    <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '0;
            act_val_q   <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            if (load) begin
                sh_val_q   <= value;
                sh_dp_q    <= dp_in;
                sh_blank_q <= blank_in;
            end
            if (boundary_s) begin
                act_val_q   <= load ? value    : sh_val_q;
                act_dp_q    <= load ? dp_in    : sh_dp_q;
                act_blank_q <= load ? blank_in : sh_blank_q;
                pending_q   <= 1'b0;
            end else if (load) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Output registers; frame_start trails the boundary by one cycle so it
    // coincides with the first pin cycle of digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q          <= '1;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            bnd_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            bnd_q         <= boundary_s;
            frame_start_q <= bnd_q;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
module tb_sseg_scan_driver;

    localparam int DIGITS   = 4;
    localparam int DIV_LOG2 = 2;
    localparam int BRIGHT_W = 2;
    localparam int SLOT     = 4;
    localparam int FRAME    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic        lz_suppress = 1'b0;
    logic [1:0]  brightness = 2'd3;
    logic [3:0]  s_an;
    logic [6:0]  s_seg;
    logic        s_dp, s_fs, s_pend;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Standard hex display table, active-low gfedcba.
    logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state: time since reset, plus what is shown / buffered.
    int          m_t = 0;
    logic [15:0] m_act_val = 16'h0, m_sh_val = 16'h0;
    logic [3:0]  m_act_dp = 4'h0, m_sh_dp = 4'h0, m_act_bl = 4'h0, m_sh_bl = 4'h0;
    bit          m_pend = 1'b0, m_prevb = 1'b0;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fs, exp_pend;

    sseg_scan_driver #(.DIGITS(DIGITS), .DIV_LOG2(DIV_LOG2), .BRIGHT_W(BRIGHT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .value       (value),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .lz_suppress (lz_suppress),
        .brightness  (brightness),
        .an          (s_an),
        .seg         (s_seg),
        .dp          (s_dp),
        .frame_start (s_fs),
        .pending     (s_pend)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock using the current inputs, then clock the DUT
    // and return at the following negedge with outputs settled.
    task automatic step();
        int cnt, idx;
        bit bnd, off;
        if (rst) begin
            m_t = 0; m_act_val = 16'h0; m_sh_val = 16'h0;
            m_act_dp = 4'h0; m_sh_dp = 4'h0; m_act_bl = 4'h0; m_sh_bl = 4'h0;
            m_pend = 1'b0; m_prevb = 1'b0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0; exp_pend = 1'b0;
        end else begin
            cnt = m_t % SLOT;
            idx = (m_t / SLOT) % DIGITS;
            bnd = ((m_t % FRAME) == FRAME - 1);
            off = m_act_bl[idx] || (lz_suppress && idx != 0 && (m_act_val >> (4*idx)) == 16'h0);
            exp_seg = off ? 7'h7F : hex_tbl[(m_act_val >> (4*idx)) & 16'hF];
            exp_dp  = off ? 1'b1 : !m_act_dp[idx];
            exp_an  = 4'hF;
            if (!off && (cnt >> (DIV_LOG2 - BRIGHT_W)) <= int'(brightness)) exp_an[idx] = 1'b0;
            exp_fs = m_prevb;
            if (load) begin
                m_sh_val = value; m_sh_dp = dp_in; m_sh_bl = blank_in;
            end
            if (bnd) begin
                m_act_val = m_sh_val; m_act_dp = m_sh_dp; m_act_bl = m_sh_bl;
                m_pend = 1'b0;
            end else if (load) begin
                m_pend = 1'b1;
            end
            exp_pend = m_pend;
            m_prevb = bnd;
            m_t++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Step until frame_start is seen (at least one step); returns steps taken.
    task automatic wait_fs(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (s_fs !== 1'b1 && n < 40);
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (3) step();
        total_cnt++; if (s_an !== 4'hF) $display("FAIL reset_an: got %h expected f", s_an); else pass_cnt++;
        total_cnt++; if (s_seg !== 7'h7F) $display("FAIL reset_seg: got %h expected 7f", s_seg); else pass_cnt++;
        total_cnt++; if (s_dp !== 1'b1) $display("FAIL reset_dp: got %b expected 1", s_dp); else pass_cnt++;
        total_cnt++; if (s_pend !== 1'b0) $display("FAIL reset_pending: got %b expected 0", s_pend); else pass_cnt++;
        total_cnt++; if (s_fs !== 1'b0) $display("FAIL reset_fs: got %b expected 0", s_fs); else pass_cnt++;
        rst = 1'b0;
        wait_fs(n);
        total_cnt++; if (n !== 17) $display("FAIL first_fs_delay: got %0d expected 17", n); else pass_cnt++;
    endtask

    task automatic test_display();
        int n;
        logic [6:0] exp_s [4] = '{7'h00, 7'h08, 7'h24, 7'h79};
        value = 16'h12A8; dp_in = 4'b0100; blank_in = 4'h0; brightness = 2'd3; lz_suppress = 1'b0;
        load = 1'b1; step(); load = 1'b0;
        total_cnt++; if (s_pend !== 1'b1) $display("FAIL disp_pending_set: got %b expected 1", s_pend); else pass_cnt++;
        wait_fs(n);
        total_cnt++; if (s_fs !== 1'b1) $display("FAIL disp_fs_timeout: got %b expected 1", s_fs); else pass_cnt++;
        total_cnt++; if (s_pend !== 1'b0) $display("FAIL disp_pending_clr: got %b expected 0", s_pend); else pass_cnt++;
        for (int i = 0; i < FRAME; i++) begin
            logic [3:0] ea;
            ea = 4'hF; ea[i/SLOT] = 1'b0;
            total_cnt++; if (s_an !== ea) $display("FAIL disp_an c%0d: got %b expected %b", i, s_an, ea); else pass_cnt++;
            total_cnt++; if (s_seg !== exp_s[i/SLOT]) $display("FAIL disp_seg c%0d: got %h expected %h", i, s_seg, exp_s[i/SLOT]); else pass_cnt++;
            total_cnt++; if (s_dp !== (i/SLOT != 2)) $display("FAIL disp_dp c%0d: got %b expected %b", i, s_dp, (i/SLOT != 2)); else pass_cnt++;
            step();
        end
    endtask

    task automatic test_lz();
        int n;
        logic [6:0] exp_s [4] = '{7'h40, 7'h30, 7'h7F, 7'h7F};
        lz_suppress = 1'b1; value = 16'h0030; dp_in = 4'h0;
        load = 1'b1; step(); load = 1'b0;
        wait_fs(n);
        for (int i = 0; i < FRAME; i++) begin
            logic [3:0] ea;
            ea = 4'hF;
            if (i/SLOT < 2) ea[i/SLOT] = 1'b0;
            total_cnt++; if (s_an !== ea) $display("FAIL lz_an c%0d: got %b expected %b", i, s_an, ea); else pass_cnt++;
            total_cnt++; if (s_seg !== exp_s[i/SLOT]) $display("FAIL lz_seg c%0d: got %h expected %h", i, s_seg, exp_s[i/SLOT]); else pass_cnt++;
            step();
        end
    endtask

    task automatic test_brightness();
        int n;
        brightness = 2'd1; lz_suppress = 1'b0;
        wait_fs(n);
        for (int i = 0; i < FRAME; i++) begin
            logic [3:0] ea;
            logic [6:0] es;
            ea = 4'hF;
            if ((i % SLOT) < 2) ea[i/SLOT] = 1'b0;
            es = (i/SLOT == 1) ? 7'h30 : 7'h40;
            total_cnt++; if (s_an !== ea) $display("FAIL bright_an c%0d: got %b expected %b", i, s_an, ea); else pass_cnt++;
            total_cnt++; if (s_seg !== es) $display("FAIL bright_seg c%0d: got %h expected %h", i, s_seg, es); else pass_cnt++;
            step();
        end
    endtask

    task automatic test_back_to_back();
        int n;
        brightness = 2'd3;
        for (int k = 0; k < FRAME && (m_t % FRAME) != 3; k++) step();
        value = 16'h0001; load = 1'b1; step(); load = 1'b0;
        for (int k = 0; k < FRAME && (m_t % FRAME) != 7; k++) step();
        value = 16'h0002; load = 1'b1; step(); load = 1'b0;
        total_cnt++; if (s_pend !== 1'b1) $display("FAIL b2b_pending_mid: got %b expected 1", s_pend); else pass_cnt++;
        for (int k = 0; k < FRAME && (m_t % FRAME) != 15; k++) step();
        value = 16'hFFFF; load = 1'b1; step(); load = 1'b0;
        total_cnt++; if (s_pend !== 1'b0) $display("FAIL b2b_pending_bypass: got %b expected 0", s_pend); else pass_cnt++;
        wait_fs(n);
        total_cnt++; if (n !== 1) $display("FAIL b2b_fs_delay: got %0d expected 1", n); else pass_cnt++;
        for (int i = 0; i < FRAME; i++) begin
            logic [3:0] ea;
            ea = 4'hF; ea[i/SLOT] = 1'b0;
            total_cnt++; if (s_an !== ea) $display("FAIL b2b_an c%0d: got %b expected %b", i, s_an, ea); else pass_cnt++;
            total_cnt++; if (s_seg !== 7'h0E) $display("FAIL b2b_seg c%0d: got %h expected 0e", i, s_seg); else pass_cnt++;
            total_cnt++; if (s_pend !== 1'b0) $display("FAIL b2b_pending c%0d: got %b expected 0", i, s_pend); else pass_cnt++;
            step();
        end
    endtask

    task automatic test_reset_mid();
        int n;
        value = 16'h1111; load = 1'b1; step(); load = 1'b0;
        for (int k = 0; k < FRAME && (m_t % FRAME) != 9; k++) step();
        rst = 1'b1; step();
        total_cnt++; if (s_an !== 4'hF) $display("FAIL rmid_an: got %h expected f", s_an); else pass_cnt++;
        total_cnt++; if (s_seg !== 7'h7F) $display("FAIL rmid_seg: got %h expected 7f", s_seg); else pass_cnt++;
        total_cnt++; if (s_dp !== 1'b1) $display("FAIL rmid_dp: got %b expected 1", s_dp); else pass_cnt++;
        total_cnt++; if (s_pend !== 1'b0) $display("FAIL rmid_pending: got %b expected 0", s_pend); else pass_cnt++;
        rst = 1'b0; step();
        total_cnt++; if (s_an !== 4'b1110) $display("FAIL rmid_restart_an: got %b expected 1110", s_an); else pass_cnt++;
        total_cnt++; if (s_seg !== 7'h40) $display("FAIL rmid_restart_seg: got %h expected 40", s_seg); else pass_cnt++;
        wait_fs(n);
        total_cnt++; if (n !== 16) $display("FAIL rmid_fs_delay: got %0d expected 16", n); else pass_cnt++;
        for (int i = 0; i < FRAME; i++) begin
            logic [3:0] ea;
            ea = 4'hF; ea[i/SLOT] = 1'b0;
            total_cnt++; if (s_an !== ea) $display("FAIL rmid_an c%0d: got %b expected %b", i, s_an, ea); else pass_cnt++;
            total_cnt++; if (s_seg !== 7'h40) $display("FAIL rmid_seg c%0d: got %h expected 40", i, s_seg); else pass_cnt++;
            step();
        end
    endtask

    task automatic test_random();
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            load        = ($urandom_range(0, 7) == 0);
            value       = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp_in       = 4'($urandom);
            blank_in    = 4'($urandom) & 4'($urandom) & 4'($urandom);
            brightness  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) lz_suppress = ~lz_suppress;
            step();
            total_cnt++; if (s_an !== exp_an) $display("FAIL rnd_an i%0d: got %b expected %b", i, s_an, exp_an); else pass_cnt++;
            total_cnt++; if (s_seg !== exp_seg) $display("FAIL rnd_seg i%0d: got %h expected %h", i, s_seg, exp_seg); else pass_cnt++;
            total_cnt++; if (s_dp !== exp_dp) $display("FAIL rnd_dp i%0d: got %b expected %b", i, s_dp, exp_dp); else pass_cnt++;
            total_cnt++; if (s_fs !== exp_fs) $display("FAIL rnd_fs i%0d: got %b expected %b", i, s_fs, exp_fs); else pass_cnt++;
            total_cnt++; if (s_pend !== exp_pend) $display("FAIL rnd_pending i%0d: got %b expected %b", i, s_pend, exp_pend); else pass_cnt++;
        end
        rst = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_display();
        test_lz();
        test_brightness();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
